// File: rtl/axi_pkg.sv
// AXI burst/response codes, FSM encodings and AR legality check shared by the burst read slave.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DELAY = 2'd1;
  localparam logic [1:0] ST_SEND  = 2'd2;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  id;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ar_req_t;

  // Only 32-bit data lanes exist; WRAP needs a power-of-two beat count of 2..16.
  function automatic logic ar_illegal(input logic [2:0] size, input logic [1:0] burst,
                                      input logic [7:0] len);
    logic wrap_len_ok;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (size > 3'd2) || (burst == 2'b11) || ((burst == BURST_WRAP) && !wrap_len_ok);
  endfunction

endpackage

// File: rtl/axi_burst_rd_slave_if.sv
// AR/R read-channel bundle between the fetch master and the burst read slave.
interface axi_burst_rd_slave_if;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  rid;

  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
    output arready, rvalid, rdata, rresp, rlast, rid
  );

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst, rready,
    input  arready, rvalid, rdata, rresp, rlast, rid
  );
endinterface

// File: rtl/axi_addr_next.sv
// Combinational next-beat byte address for FIXED/INCR/WRAP bursts.
module axi_addr_next
  import axi_pkg::*;
(
  input  logic [31:0] addr,
  input  logic [2:0]  size,
  input  logic [7:0]  len,
  input  logic [1:0]  burst,
  output logic [31:0] addr_next
);

  logic [31:0] step;
  logic [31:0] wrap_mask;
  logic [31:0] incr;

  always_comb begin
    step      = 32'd1 << size;
    wrap_mask = (({24'd0, len} + 32'd1) << size) - 32'd1;
    incr      = addr + step;
    addr_next = addr;
    case (burst)
      BURST_INCR: addr_next = incr;
      // Low bits advance inside the wrap window, upper bits stay put.
      BURST_WRAP: addr_next = (addr & ~wrap_mask) | (incr & wrap_mask);
      default:    addr_next = addr;
    endcase
  end

endmodule

// File: rtl/axi_burst_rd_slave.sv
// AXI4 read-only burst slave over an inline word memory with a backdoor preload port.
// First beat LATENCY+1 cycles after AR accept; one request at a time; R beats held while rready is low.
module axi_burst_rd_slave
  import axi_pkg::*;
#(
  parameter int          MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          LATENCY   = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  axi_burst_rd_slave_if.slave  io_slave,
  input  logic                 init_wen,
  input  logic [31:0]          init_addr,
  input  logic [31:0]          init_data
);

  localparam int         IDXW     = $clog2(MEM_WORDS);
  localparam logic [3:0] DLY_LAST = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  logic [31:0] mem [MEM_WORDS];

  logic [1:0]  state;
  ar_req_t     req_q;
  logic        req_err_q;
  logic [7:0]  beat_cnt;
  logic [3:0]  dly_cnt;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;

  logic            ar_hs;
  logic            r_hs;
  logic            last_beat;
  logic            new_err;
  logic [31:0]     addr_nxt;
  logic            ld_en;
  logic [31:0]     ld_addr;
  logic            ld_err;
  logic [31:0]     ld_off;
  logic            ld_in_range;
  logic [IDXW-1:0] ld_idx;
  logic [31:0]     ld_word;
  logic [31:0]     init_off;
  logic            init_in_range;
  logic [IDXW-1:0] init_idx;

  assign ar_hs     = (state == ST_IDLE) && io_slave.arvalid;
  assign r_hs      = (state == ST_SEND) && io_slave.rready;
  assign last_beat = (beat_cnt == req_q.len);
  assign new_err   = ar_illegal(io_slave.arsize, io_slave.arburst, io_slave.arlen);

  axi_addr_next u_addr_next (
    .addr      (req_q.addr),
    .size      (req_q.size),
    .len       (req_q.len),
    .burst     (req_q.burst),
    .addr_next (addr_nxt)
  );

  // Single read port: the address comes from AR (zero latency), the latch, or the next beat.
  always_comb begin
    ld_en   = 1'b0;
    ld_addr = req_q.addr;
    ld_err  = req_err_q;
    case (state)
      ST_IDLE: begin
        ld_en   = ar_hs && (LATENCY == 0);
        ld_addr = io_slave.araddr;
        ld_err  = new_err;
      end
      ST_DELAY: ld_en = (dly_cnt == DLY_LAST);
      ST_SEND: begin
        ld_en   = r_hs && !last_beat;
        ld_addr = addr_nxt;
      end
      default: ld_en = 1'b0;
    endcase
  end

  assign ld_off        = ld_addr - BASE_ADDR;
  assign ld_in_range   = (ld_addr >= BASE_ADDR) && ((ld_off >> (IDXW + 2)) == 32'd0);
  assign ld_idx        = ld_off[IDXW+1:2];
  assign init_off      = init_addr - BASE_ADDR;
  assign init_in_range = (init_addr >= BASE_ADDR) && ((init_off >> (IDXW + 2)) == 32'd0);
  assign init_idx      = init_off[IDXW+1:2];

  // A backdoor write on the same edge as a beat load is forwarded to that beat.
  always_comb begin
    ld_word = 32'd0;
    if (ld_in_range) begin
      if (init_wen && init_in_range && (init_idx == ld_idx)) ld_word = init_data;
      else                                                   ld_word = mem[ld_idx];
    end
  end

  always_ff @(posedge clock) begin
    if (init_wen && init_in_range) mem[init_idx] <= init_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      req_q     <= '0;
      req_err_q <= 1'b0;
      beat_cnt  <= 8'd0;
      dly_cnt   <= 4'd0;
      rdata_q   <= 32'd0;
      rresp_q   <= RESP_OKAY;
    end else begin
      if (ld_en) begin
        rdata_q <= ld_word;
        rresp_q <= (ld_err || !ld_in_range) ? RESP_SLVERR : RESP_OKAY;
      end
      case (state)
        ST_IDLE: begin
          if (ar_hs) begin
            req_q     <= '{addr: io_slave.araddr, id: io_slave.arid, len: io_slave.arlen,
                           size: io_slave.arsize, burst: io_slave.arburst};
            req_err_q <= new_err;
            beat_cnt  <= 8'd0;
            dly_cnt   <= 4'd0;
            state     <= (LATENCY == 0) ? ST_SEND : ST_DELAY;
          end
        end
        ST_DELAY: begin
          if (dly_cnt == DLY_LAST) state <= ST_SEND;
          else                     dly_cnt <= dly_cnt + 4'd1;
        end
        ST_SEND: begin
          if (r_hs) begin
            if (last_beat) begin
              state <= ST_IDLE;
            end else begin
              req_q.addr <= addr_nxt;
              beat_cnt   <= beat_cnt + 8'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign io_slave.arready = !reset && (state == ST_IDLE);
  assign io_slave.rvalid  = !reset && (state == ST_SEND);
  assign io_slave.rlast   = !reset && (state == ST_SEND) && last_beat;
  assign io_slave.rdata   = reset ? 32'd0 : rdata_q;
  assign io_slave.rresp   = reset ? RESP_OKAY : rresp_q;
  assign io_slave.rid     = reset ? 4'd0 : req_q.id;

endmodule

// File: tb/tb_axi_burst_rd_slave.sv
// Directed plus randomized bench for axi_burst_rd_slave against an arithmetic burst model.
module tb_axi_burst_rd_slave;
  import axi_pkg::*;

  localparam int          MEM_WORDS = 1024;
  localparam logic [31:0] BASE      = 32'h8000_0000;
  localparam int          LAT       = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        init_wen = 1'b0;
  logic [31:0] init_addr = 32'd0;
  logic [31:0] init_data = 32'd0;

  axi_burst_rd_slave_if io_slave ();

  axi_burst_rd_slave #(.MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE), .LATENCY(LAT)) dut (
    .clock     (clock),
    .reset     (reset),
    .io_slave  (io_slave),
    .init_wen  (init_wen),
    .init_addr (init_addr),
    .init_data (init_data)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl [MEM_WORDS];
  logic [31:0] exp_d [256];
  logic [1:0]  exp_r [256];
  logic        exp_chk_data;
  int          t_ar;
  int          t_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Assumes the caller sits on a falling edge; the write lands on the next rising edge.
  task automatic bd_write(input logic [31:0] a, input logic [31:0] d);
    longint off;
    init_wen  = 1'b1;
    init_addr = a;
    init_data = d;
    @(negedge clock);
    init_wen  = 1'b0;
    off = longint'(a) - longint'(BASE);
    if (off >= 0 && off / 4 < MEM_WORDS) mdl[int'(off / 4)] = d;
  endtask

  // Beat i address from first principles: fixed, linear, or modulo the wrap window.
  task automatic model(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                       input logic [1:0] bt);
    longint bytes, wsz, lo, ai;
    logic   legal_wrap, berr;
    legal_wrap   = len inside {8'd1, 8'd3, 8'd7, 8'd15};
    berr         = (size > 3'd2) || (bt == 2'b11) || (bt == 2'b10 && !legal_wrap);
    exp_chk_data = (bt != 2'b11) && !(bt == 2'b10 && !legal_wrap);
    bytes = longint'(1) << size;
    wsz   = (longint'(len) + 1) * bytes;
    lo    = longint'(a) - (longint'(a) % wsz);
    for (int i = 0; i <= int'(len); i++) begin
      if (bt == 2'b00)      ai = longint'(a);
      else if (bt == 2'b10) ai = lo + ((longint'(a) - lo + i * bytes) % wsz);
      else                  ai = longint'(a) + i * bytes;
      ai = ai & 64'hFFFF_FFFF;
      if (ai >= longint'(BASE) && (ai - longint'(BASE)) / 4 < MEM_WORDS) begin
        exp_d[i] = mdl[int'((ai - longint'(BASE)) / 4)];
        exp_r[i] = berr ? 2'b10 : 2'b00;
      end else begin
        exp_d[i] = 32'd0;
        exp_r[i] = 2'b10;
      end
    end
  endtask

  // mode 0: rready always high, 1: random rready, 2: stall beat 2 for three cycles.
  task automatic burst(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] bt, input int mode,
                       input logic hold, input string tag);
    int   k, first, stall, guard;
    logic rr;
    model(a, len, size, bt);
    io_slave.arvalid = 1'b1;
    io_slave.araddr  = a;
    io_slave.arid    = id;
    io_slave.arlen   = len;
    io_slave.arsize  = size;
    io_slave.arburst = bt;
    guard = 0;
    while (!io_slave.arready && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    chk({tag, " ar_accept"}, 32'(guard < 200), 32'd1);
    t_ar = cyc;
    @(negedge clock);
    if (!hold) io_slave.arvalid = 1'b0;
    k = 0; first = -1; stall = 0; guard = 0;
    while (k <= int'(len) && guard < 400) begin
      if (mode == 0)      rr = 1'b1;
      else if (mode == 1) rr = ($urandom_range(0, 3) != 0);
      else                rr = !(k == 1 && stall < 3);
      io_slave.rready = rr;
      chk({tag, " arready_busy"}, 32'(io_slave.arready), 32'd0);
      if (io_slave.rvalid) begin
        if (first < 0) begin
          first = cyc;
          chk({tag, " first_beat_cycle"}, 32'(cyc), 32'(t_ar + 1 + LAT));
        end
        if (exp_chk_data) chk({tag, " rdata"}, io_slave.rdata, exp_d[k]);
        chk({tag, " rresp"}, 32'(io_slave.rresp), 32'(exp_r[k]));
        chk({tag, " rlast"}, 32'(io_slave.rlast), 32'(k == int'(len)));
        chk({tag, " rid"}, 32'(io_slave.rid), 32'(id));
        if (rr) begin
          if (mode == 0) chk({tag, " no_bubble"}, 32'(cyc), 32'(first + k));
          t_last = cyc;
          k++;
        end else begin
          stall++;
        end
      end
      @(negedge clock);
      guard++;
    end
    io_slave.rready = 1'b0;
    chk({tag, " beat_count"}, 32'(k), 32'(int'(len) + 1));
    chk({tag, " arready_after"}, 32'(io_slave.arready), 32'd1);
    chk({tag, " rvalid_after"}, 32'(io_slave.rvalid), 32'd0);
  endtask

  initial begin
    int          g, prev_last, r;
    logic [31:0] a;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  bt;

    io_slave.arvalid = 1'b0;
    io_slave.araddr  = 32'd0;
    io_slave.arid    = 4'd0;
    io_slave.arlen   = 8'd0;
    io_slave.arsize  = 3'd0;
    io_slave.arburst = 2'd0;
    io_slave.rready  = 1'b0;

    repeat (3) @(negedge clock);
    chk("reset arready", 32'(io_slave.arready), 32'd0);
    chk("reset rvalid", 32'(io_slave.rvalid), 32'd0);
    chk("reset rdata", io_slave.rdata, 32'd0);
    chk("reset rresp", 32'(io_slave.rresp), 32'd0);
    chk("reset rlast", 32'(io_slave.rlast), 32'd0);
    chk("reset rid", 32'(io_slave.rid), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("idle arready", 32'(io_slave.arready), 32'd1);

    for (int i = 0; i < MEM_WORDS; i++) bd_write(BASE + 32'(4 * i), $urandom);
    bd_write(BASE + 32'd0,  32'h11);
    bd_write(BASE + 32'd4,  32'h22);
    bd_write(BASE + 32'd8,  32'h33);
    bd_write(BASE + 32'd12, 32'h44);
    // Out-of-range backdoor writes must not alias into the array.
    bd_write(BASE + 32'(4 * MEM_WORDS), 32'hDEAD_BEEF);
    bd_write(BASE - 32'd4, 32'hCAFE_F00D);

    burst(BASE, 4'd5, 8'd3, 3'd2, BURST_INCR, 0, 1'b0, "incr");
    burst(BASE, 4'd5, 8'd3, 3'd2, BURST_INCR, 2, 1'b0, "backpressure");
    burst(BASE + 32'd8, 4'd6, 8'd3, 3'd2, BURST_WRAP, 0, 1'b0, "wrap");
    burst(BASE, 4'd7, 8'd1, 3'd2, 2'b11, 0, 1'b0, "bad_burst");
    burst(BASE + 32'(4 * MEM_WORDS), 4'd8, 8'd0, 3'd2, BURST_INCR, 0, 1'b0, "out_of_range");
    burst(BASE, 4'd1, 8'd0, 3'd2, BURST_INCR, 0, 1'b0, "alias_word0");

    burst(BASE + 32'd4, 4'd3, 8'd0, 3'd2, BURST_INCR, 0, 1'b1, "b2b_first");
    prev_last = t_last;
    burst(BASE + 32'd4, 4'd3, 8'd0, 3'd2, BURST_INCR, 0, 1'b0, "b2b_second");
    chk("b2b accept_cycle", 32'(t_ar), 32'(prev_last + 1));

    // Reset lands while beat 2 of a 4-beat burst is on the bus.
    io_slave.arvalid = 1'b1;
    io_slave.araddr  = BASE;
    io_slave.arid    = 4'd9;
    io_slave.arlen   = 8'd3;
    io_slave.arsize  = 3'd2;
    io_slave.arburst = BURST_INCR;
    io_slave.rready  = 1'b1;
    @(negedge clock);
    io_slave.arvalid = 1'b0;
    g = 0;
    while (!io_slave.rvalid && g < 50) begin
      @(negedge clock);
      g++;
    end
    chk("rst_mid beat1_seen", 32'(io_slave.rvalid), 32'd1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("rst_mid arready", 32'(io_slave.arready), 32'd0);
    chk("rst_mid rvalid", 32'(io_slave.rvalid), 32'd0);
    chk("rst_mid rdata", io_slave.rdata, 32'd0);
    chk("rst_mid rresp", 32'(io_slave.rresp), 32'd0);
    chk("rst_mid rlast", 32'(io_slave.rlast), 32'd0);
    chk("rst_mid rid", 32'(io_slave.rid), 32'd0);
    reset = 1'b0;
    io_slave.rready = 1'b0;
    @(negedge clock);
    chk("rst_release arready", 32'(io_slave.arready), 32'd1);
    repeat (LAT + 2) @(negedge clock);
    chk("rst_release no_stray_beat", 32'(io_slave.rvalid), 32'd0);
    burst(BASE, 4'd10, 8'd3, 3'd2, BURST_INCR, 0, 1'b0, "after_reset");

    for (int n = 0; n < 30; n++) begin
      r = int'($urandom_range(0, 9));
      bt = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 9) == 0) bt = 2'b11;
      size = 3'($urandom_range(0, 2));
      if ($urandom_range(0, 9) == 0) size = 3'd3;
      if (bt == BURST_WRAP && $urandom_range(0, 4) != 0) begin
        case ($urandom_range(0, 3))
          0:       len = 8'd1;
          1:       len = 8'd3;
          2:       len = 8'd7;
          default: len = 8'd15;
        endcase
      end else begin
        len = 8'($urandom_range(0, 15));
      end
      if (r < 8)       a = BASE + 32'(4 * $urandom_range(0, MEM_WORDS - 1));
      else if (r == 8) a = BASE + 32'(4 * (MEM_WORDS - 3));
      else             a = BASE - 32'd8;
      bd_write(BASE + 32'(4 * $urandom_range(0, MEM_WORDS - 1)), $urandom);
      burst(a, 4'($urandom_range(0, 15)), len, size, bt, 1, 1'b0, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_burst_rd_slave.md
# axi_burst_rd_slave

AXI4 read-only burst responder backed by an internal word-addressed memory. It is the slave side of the instruction-fetch AR/R channel. It accepts one read request at a time, waits a programmable number of cycles, then returns `arlen+1` beats with correct `rid`, `rresp` and `rlast`. It serves as the simulation memory model behind the fetch unit and as a simple on-chip boot ROM/SRAM; a backdoor port preloads contents.

## Interface
- `MEM_WORDS`, 1024, memory depth in 32-bit words (power of two)
- `BASE_ADDR`, 32'h8000_0000, byte address of word 0
- `LATENCY`, 2, cycles from AR handshake to first `rvalid` beyond the minimum (0..15)
- `clock` in 1 — rising-edge clock
- `reset` in 1 — synchronous, active-high
- `io_slave_arvalid` in 1 — request valid
- `io_slave_arready` out 1 — request accepted
- `io_slave_araddr` in 32 — start byte address
- `io_slave_arid` in 4 — transaction id
- `io_slave_arlen` in 8 — beats minus one
- `io_slave_arsize` in 3 — bytes per beat, log2
- `io_slave_arburst` in 2 — 00 FIXED, 01 INCR, 10 WRAP
- `io_slave_rvalid` out 1 — beat valid
- `io_slave_rready` in 1 — beat accepted
- `io_slave_rdata` out 32 — beat data
- `io_slave_rresp` out 2 — 00 OKAY, 10 SLVERR
- `io_slave_rlast` out 1 — final beat
- `io_slave_rid` out 4 — echo of latched `arid`
- `init_wen` in 1 — backdoor write enable
- `init_addr` in 32 — backdoor byte address (word-aligned)
- `init_data` in 32 — backdoor data

## Operation
- FSM states: IDLE, DELAY, SEND.
- IDLE:
  - `arready`=1.
  - On `arvalid && arready`, latch addr/id/len/size/burst and clear the beat counter.
  - Go to DELAY if `LATENCY`>0, else SEND.
- DELAY: a 4-bit counter counts `LATENCY` cycles, then the FSM goes to SEND.
- SEND:
  - `rvalid`=1.
  - On `rvalid && rready`: if `rlast`, go to IDLE; else advance the address and load the next beat.
- Address advance:
  - FIXED: no change.
  - INCR: `addr += 1<<size`.
  - WRAP: increment within the boundary `(len+1)<<size`; low bits wrap and high bits are kept.
- Error checks, latched at AR accept:
  - SLVERR when `arsize`>2, `arburst`==11, or WRAP with `len` not in {1,3,7,15}. All `len+1` beats are still returned.
  - Per beat, SLVERR with `rdata`=0 when the word index `(addr-BASE_ADDR)>>2` is ≥ `MEM_WORDS` or `addr` < `BASE_ADDR`.
- `rdata` is always the full aligned word `mem[addr[..:2]]`. Narrow beats rely on the master selecting lanes.
- `rlast` = (beat counter == latched len).
- `rid` is held at the latched `arid` for every beat.
- Backdoor write to in-range `init_addr` updates memory at the clock edge. Out-of-range backdoor writes are ignored.

## Timing
- While `reset` is high, every output is 0: `arready`, `rvalid`, `rdata`, `rresp`, `rlast`, `rid`. The FSM goes to IDLE and any in-flight burst is dropped with no further beats.
- Memory contents are not cleared by reset.
- AR handshake at cycle T: first `rvalid` at T+1+`LATENCY`.
- `arready` is 0 from T+1 until the cycle after the last R handshake. Only one outstanding request is allowed.
- Back-to-back beats: if `rready` stays high, one beat per cycle with no bubbles.
- While `rvalid`=1 and `rready`=0, `rdata`, `rresp`, `rlast` and `rid` are held stable.
- `rdata` is registered. It is read from memory when entering SEND and at each non-last handshake.
- Backdoor write during a burst:
  - A beat already presented keeps its value.
  - Later beats see the new data if the write occurred at or before the edge that loads them.
- After the last handshake at cycle L, `arready`=1 at L+1. The earliest next first beat is L+2+`LATENCY`.

## Structure
- Shared package `axi_pkg` holds:
  - burst codes `BURST_FIXED`/`BURST_INCR`/`BURST_WRAP`
  - resp codes `RESP_OKAY`/`RESP_SLVERR`
  - FSM state encodings
- One sub-module, `axi_addr_next`: purely combinational next-beat address from (addr, size, len, burst).
- The memory array is inline, with a single read port and the backdoor write port.

## Test plan
- INCR burst, `LATENCY`=2:
  - Stimulus: preload words 0..3 = 11,22,33,44; AR addr 8000_0000, len 3, size 2, id 5 at T.
  - Required: beats at T+3..T+6 with data 11,22,33,44; rid 5; rlast only on the 4th beat; resp OKAY.
- Backpressure:
  - Stimulus: same burst with `rready` low for 3 cycles on beat 2.
  - Required: `rdata`=22 and `rlast`=0 are held stable, and no beat is lost.
- WRAP:
  - Stimulus: AR addr 8000_0008, len 3, size 2, burst 10.
  - Required: data order 33,44,11,22.
- Errors:
  - arburst 11 with len 1 → 2 beats, both SLVERR.
  - AR addr BASE+4*MEM_WORDS → SLVERR with rdata 0.
- Reset mid-burst:
  - Stimulus: assert reset after beat 1.
  - Required: all outputs 0 next cycle; after release, `arready`=1 and a fresh burst completes normally.
- Back-to-back:
  - Stimulus: two single-beat requests with `arvalid` held high.
  - Required: second AR accepted at L+1; its beat appears at L+2+`LATENCY`.
